// File: rtl/serial_in_status.sv
// Receive-side deserializer for the alarm status link: rebuilds the WIDTH-bit
// alarm state sent MSB first and flags completed, changed and truncated frames.
module serial_in_status #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             status_send,
  input  logic             status_out,
  output logic [WIDTH-1:0] state_out,
  output logic             state_valid,
  output logic             state_changed,
  output logic             frame_err,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Link handshake: a frame is a run of WIDTH cycles with status_send high,
  // one data bit per cycle on status_out; there is no back-pressure, so every
  // cycle with send_s high is consumed as a bit.

  logic send_s;
  logic data_s;

  // Both link inputs pass through pipes of identical depth so bits stay aligned.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign send_s = status_send;
      assign data_s = status_out;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] send_pipe;
      logic [SYNC_STAGES-1:0] data_pipe;

      always_ff @(posedge clk) begin
        if (reset) begin
          send_pipe <= '0;
          data_pipe <= '0;
        end else begin
          send_pipe <= SYNC_STAGES'({send_pipe, status_send});
          data_pipe <= SYNC_STAGES'({data_pipe, status_out});
        end
      end

      assign send_s = send_pipe[SYNC_STAGES-1];
      assign data_s = data_pipe[SYNC_STAGES-1];
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_in;
  logic [WIDTH-1:0] out_d;
  logic             valid_d, changed_d, err_d;
  logic             complete;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      state_out     <= RESET_STATE;
      state_valid   <= 1'b0;
      state_changed <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      state_out     <= out_d;
      state_valid   <= valid_d;
      state_changed <= changed_d;
      frame_err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    out_d     = state_out;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    err_d     = 1'b0;
    complete  = 1'b0;

    // A new frame starts from an empty word; inside a frame bits enter at LSB.
    if (state_q == IDLE) word_in = WIDTH'(data_s);
    else                 word_in = WIDTH'({shift_q, data_s});

    case (state_q)
      IDLE: begin
        if (send_s) begin
          if (WIDTH == 1) begin
            complete = 1'b1;
          end else begin
            shift_d = word_in;
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (!send_s) begin
          err_d   = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          complete = 1'b1;
        end else begin
          shift_d = word_in;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Returning to IDLE lets a still-high send_s open the next frame at once.
    if (complete) begin
      out_d     = word_in;
      valid_d   = 1'b1;
      changed_d = (word_in != state_out);
      shift_d   = word_in;
      cnt_d     = '0;
      state_d   = IDLE;
    end
  end

  assign busy = (state_q == RECV);

  a_valid_err_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(state_valid && frame_err));
  a_changed_needs_valid : assert property (@(posedge clk) disable iff (reset)
    state_changed |-> state_valid);
  a_cnt_in_range : assert property (@(posedge clk) disable iff (reset)
    cnt_q <= LAST);

endmodule

// File: tb/tb_serial_in_status.sv
// Bench for serial_in_status: SYNC_STAGES=0 and SYNC_STAGES=2 instances share
// one stimulus stream and are checked against a frame-level reference model.
module tb_serial_in_status;

  localparam int         W       = 4;
  localparam logic [3:0] RST_VAL = 4'h6;

  logic         clk = 1'b0;
  logic         reset, status_send, status_out;
  logic [W-1:0] state_out0, state_out2;
  logic         state_valid0, state_changed0, frame_err0, busy0;
  logic         state_valid2, state_changed2, frame_err2, busy2;

  int checks = 0;
  int errors = 0;

  // Per-cycle history: inputs driven before edge c, outputs sampled just after.
  bit         rst_h[$];
  bit         send_h[$];
  bit         data_h[$];
  logic [7:0] obs0_h[$];
  logic [7:0] obs2_h[$];
  logic [7:0] exp_q[$];

  serial_in_status #(.WIDTH(W), .SYNC_STAGES(0), .RESET_STATE(RST_VAL)) dut0 (
    .clk(clk), .reset(reset), .status_send(status_send), .status_out(status_out),
    .state_out(state_out0), .state_valid(state_valid0), .state_changed(state_changed0),
    .frame_err(frame_err0), .busy(busy0));

  serial_in_status #(.WIDTH(W), .SYNC_STAGES(2), .RESET_STATE(RST_VAL)) dut2 (
    .clk(clk), .reset(reset), .status_send(status_send), .status_out(status_out),
    .state_out(state_out2), .state_valid(state_valid2), .state_changed(state_changed2),
    .frame_err(frame_err2), .busy(busy2));

  always #5 clk = ~clk;

  // Reference model: inputs are delayed s cycles (a reset inside the delay
  // window wipes them), each run of W high send cycles yields one word, a
  // run that ends early yields one error; busy means a partial word is held.
  function automatic void build_model(input int s);
    int run, word, cur;
    bit es, ed, blk, v, ch, er;
    exp_q.delete();
    run  = 0;
    word = 0;
    cur  = RST_VAL;
    for (int c = 0; c < rst_h.size(); c++) begin
      v  = 0;
      ch = 0;
      er = 0;
      if (rst_h[c]) begin
        cur  = RST_VAL;
        run  = 0;
        word = 0;
      end else begin
        blk = (c < s);
        for (int k = c - s; k < c; k++) if (k >= 0 && rst_h[k]) blk = 1;
        es = blk ? 1'b0 : send_h[c-s];
        ed = blk ? 1'b0 : data_h[c-s];
        if (es) begin
          if (run == 0) word = 0;
          word = (word * 2 + int'(ed)) % (1 << W);
          run++;
          if (run == W) begin
            v   = 1;
            ch  = (word != cur);
            cur = word;
            run = 0;
          end
        end else if (run > 0) begin
          er  = 1;
          run = 0;
        end
      end
      exp_q.push_back({4'(cur), v, ch, er, (run > 0)});
    end
  endfunction

  task automatic cyc(input bit r, input bit s, input bit d);
    reset       = r;
    status_send = s;
    status_out  = d;
    @(posedge clk);
    #1;
    rst_h.push_back(r);
    send_h.push_back(s);
    data_h.push_back(d);
    obs0_h.push_back({state_out0, state_valid0, state_changed0, frame_err0, busy0});
    obs2_h.push_back({state_out2, state_valid2, state_changed2, frame_err2, busy2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic frame(input logic [W-1:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) cyc(1'b0, 1'b1, v[W-1-i]);
  endtask

  task automatic test_reset();
    int seg;
    seg = obs0_h.size();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(3);
    checks++;
    if (obs0_h[seg+2] !== {RST_VAL, 4'b0000}) begin
      errors++;
      $display("FAIL reset_value dut0 got %h exp %h", obs0_h[seg+2], {RST_VAL, 4'b0000});
    end
    build_model(0);
    for (int i = seg; i < obs0_h.size(); i++) begin
      checks++;
      if (obs0_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_model dut0 cyc %0d got %h exp %h", i, obs0_h[i], exp_q[i]);
      end
    end
    build_model(2);
    for (int i = seg; i < obs2_h.size(); i++) begin
      checks++;
      if (obs2_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_model dut2 cyc %0d got %h exp %h", i, obs2_h[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_basic();
    int seg, f, nbusy;
    seg = obs0_h.size();
    f   = seg;
    frame(4'hA, 4);
    idle(4);
    checks++;
    if (obs0_h[f+W-1] !== {4'hA, 4'b1100}) begin
      errors++;
      $display("FAIL basic_word dut0 got %h exp %h", obs0_h[f+W-1], {4'hA, 4'b1100});
    end
    nbusy = 0;
    for (int i = seg; i < obs0_h.size(); i++) nbusy += int'(obs0_h[i][0]);
    checks++;
    if (nbusy != 3) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d exp 3", nbusy);
    end
    build_model(0);
    for (int i = seg; i < obs0_h.size(); i++) begin
      checks++;
      if (obs0_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_model dut0 cyc %0d got %h exp %h", i, obs0_h[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_repeat();
    int f;
    f = obs0_h.size();
    frame(4'hA, 4);
    idle(4);
    checks++;
    if (obs0_h[f+W-1] !== {4'hA, 4'b1000}) begin
      errors++;
      $display("FAIL repeat_nochange dut0 got %h exp %h", obs0_h[f+W-1], {4'hA, 4'b1000});
    end
    build_model(0);
    for (int i = f; i < obs0_h.size(); i++) begin
      checks++;
      if (obs0_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL repeat_model dut0 cyc %0d got %h exp %h", i, obs0_h[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_truncated();
    int seg, nerr, nval;
    seg = obs0_h.size();
    frame(4'hF, 2);
    idle(5);
    nerr = 0;
    nval = 0;
    for (int i = seg; i < obs0_h.size(); i++) begin
      nerr += int'(obs0_h[i][1]);
      nval += int'(obs0_h[i][3]);
    end
    checks++;
    if (nerr != 1 || nval != 0) begin
      errors++;
      $display("FAIL trunc_pulses err=%0d valid=%0d exp err=1 valid=0", nerr, nval);
    end
    checks++;
    if (obs0_h[obs0_h.size()-1] !== {4'hA, 4'b0000}) begin
      errors++;
      $display("FAIL trunc_hold dut0 got %h exp %h", obs0_h[obs0_h.size()-1], {4'hA, 4'b0000});
    end
    build_model(2);
    for (int i = seg; i < obs2_h.size(); i++) begin
      checks++;
      if (obs2_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL trunc_model dut2 cyc %0d got %h exp %h", i, obs2_h[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int f;
    f = obs0_h.size();
    frame(4'h3, 4);
    frame(4'hC, 4);
    idle(4);
    checks++;
    if (obs0_h[f+W-1] !== {4'h3, 4'b1100}) begin
      errors++;
      $display("FAIL b2b_first dut0 got %h exp %h", obs0_h[f+W-1], {4'h3, 4'b1100});
    end
    checks++;
    if (obs0_h[f+2*W-1] !== {4'hC, 4'b1100}) begin
      errors++;
      $display("FAIL b2b_second dut0 got %h exp %h", obs0_h[f+2*W-1], {4'hC, 4'b1100});
    end
    build_model(2);
    for (int i = f; i < obs2_h.size(); i++) begin
      checks++;
      if (obs2_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_model dut2 cyc %0d got %h exp %h", i, obs2_h[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seg, f;
    seg = obs0_h.size();
    frame(4'hB, 2);
    cyc(1'b1, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (obs0_h[seg+3] !== {RST_VAL, 4'b0000}) begin
      errors++;
      $display("FAIL midreset_quiet dut0 got %h exp %h", obs0_h[seg+3], {RST_VAL, 4'b0000});
    end
    f = obs0_h.size();
    frame(4'h5, 4);
    idle(4);
    checks++;
    if (obs0_h[f+W-1] !== {4'h5, 4'b1100}) begin
      errors++;
      $display("FAIL midreset_next dut0 got %h exp %h", obs0_h[f+W-1], {4'h5, 4'b1100});
    end
    build_model(2);
    for (int i = seg; i < obs2_h.size(); i++) begin
      checks++;
      if (obs2_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_model dut2 cyc %0d got %h exp %h", i, obs2_h[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sync_latency();
    int f, i0, i2;
    f = obs0_h.size();
    frame(4'h9, 4);
    idle(6);
    i0 = -1;
    i2 = -1;
    for (int i = obs0_h.size() - 1; i >= f; i--) begin
      if (obs0_h[i][3]) i0 = i;
      if (obs2_h[i][3]) i2 = i;
    end
    checks++;
    if (i0 - f != W - 1) begin
      errors++;
      $display("FAIL sync0_latency got %0d exp %0d", i0 - f, W - 1);
    end
    checks++;
    if (i2 - i0 != 2 || i0 < 0) begin
      errors++;
      $display("FAIL sync2_extra_latency got %0d exp 2", i2 - i0);
    end
    checks++;
    if (obs2_h[obs2_h.size()-1][7:4] !== 4'h9) begin
      errors++;
      $display("FAIL sync2_word got %h exp 9", obs2_h[obs2_h.size()-1][7:4]);
    end
  endtask

  task automatic test_random();
    int seg, kind;
    seg = obs0_h.size();
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        frame(4'($urandom_range(0, 15)), $urandom_range(0, 3));
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (kind <= 2) begin
        frame(4'($urandom_range(0, 15)), $urandom_range(1, W - 1));
        idle($urandom_range(1, 3));
      end else if (kind <= 6) begin
        frame(4'($urandom_range(0, 15)), W);
        idle($urandom_range(0, 2));
      end else begin
        frame(4'($urandom_range(0, 15)), W);
        frame(4'($urandom_range(0, 15)), W);
        idle($urandom_range(0, 3));
      end
    end
    idle(5);
    build_model(0);
    for (int i = seg; i < obs0_h.size(); i++) begin
      checks++;
      if (obs0_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_model dut0 cyc %0d got %h exp %h", i, obs0_h[i], exp_q[i]);
      end
    end
    build_model(2);
    for (int i = seg; i < obs2_h.size(); i++) begin
      checks++;
      if (obs2_h[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_model dut2 cyc %0d got %h exp %h", i, obs2_h[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    status_send = 1'b0;
    status_out  = 1'b0;
    test_reset();
    test_basic();
    test_repeat();
    test_truncated();
    test_back_to_back();
    test_reset_mid();
    test_sync_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
